// File: rtl/load_store_unit.sv
// load_store_unit: data-memory initiator with B/H/W/D load extension and sub-doubleword read-modify-write stores (optional MISALIGN_TRAP_EN traps misaligned accesses)
module load_store_unit #(
    parameter int XLEN  = 64,
    parameter int DEPTH = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [1:0]      req_size,
    input  logic            req_unsigned,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            resp_valid,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_err,
    output logic [XLEN-1:0] mem_addr,
    output logic            mem_rd,
    output logic            mem_wr,
    output logic [XLEN-1:0] mem_wr_data,
    input  logic [XLEN-1:0] mem_rd_data
);
    localparam logic [2:0] IDLE = 3'd0, RD = 3'd1, CAP = 3'd2, WR = 3'd3, RESP = 3'd4;
    logic [2:0]      state_q, state_d;
    logic            we_q, uns_q, err_q;
    logic [1:0]      size_q;
    logic [XLEN-1:0] addr_q, wdata_q, data_q;
    logic [XLEN-1:0] sz_mask, addr_al, lane_mask, shifted, loaded, merged;
    logic [5:0]      lane;
    logic            oor, err;
    assign sz_mask = (XLEN'(1) << req_size) - XLEN'(1);
    assign oor     = (req_addr >> 3) >= XLEN'(DEPTH);
`ifdef MISALIGN_TRAP_EN
    assign err     = oor | (|(req_addr & sz_mask));
    assign addr_al = req_addr;
`else
    assign err     = oor;
    assign addr_al = req_addr & ~sz_mask;
`endif
    assign lane      = {addr_q[2:0], 3'b000};
    assign lane_mask = (size_q == 2'd0 ? XLEN'(8'hFF) :
                        size_q == 2'd1 ? XLEN'(16'hFFFF) :
                        size_q == 2'd2 ? XLEN'(32'hFFFF_FFFF) : {XLEN{1'b1}}) << lane;
    assign shifted   = mem_rd_data >> lane;
    assign loaded    = size_q == 2'd0 ? {{(XLEN-8){~uns_q & shifted[7]}}, shifted[7:0]} :
                       size_q == 2'd1 ? {{(XLEN-16){~uns_q & shifted[15]}}, shifted[15:0]} :
                       size_q == 2'd2 ? {{(XLEN-32){~uns_q & shifted[31]}}, shifted[31:0]} : shifted;
    assign merged    = (mem_rd_data & ~lane_mask) | ((wdata_q << lane) & lane_mask);
    assign req_ready   = state_q == IDLE;
    assign mem_rd      = state_q == RD;
    assign mem_wr      = state_q == WR;
    assign mem_addr    = (mem_rd || mem_wr) ? addr_q >> 3 : '0;
    assign mem_wr_data = mem_wr ? data_q : '0;
    assign resp_valid  = state_q == RESP;
    assign resp_err    = resp_valid & err_q;
    assign resp_rdata  = (resp_valid && !we_q && !err_q) ? data_q : '0;
    // Sequencing: errors skip memory, full-dword stores write directly, everything else reads first
    always_comb begin
        state_d = IDLE;
        case (state_q)
            IDLE:    state_d = !req_valid ? IDLE : err ? RESP : (req_we && req_size == 2'd3) ? WR : RD;
            RD:      state_d = CAP;
            CAP:     state_d = we_q ? WR : RESP;
            WR:      state_d = RESP;
            default: state_d = IDLE;
        endcase
    end
    // Request capture, read-data capture (extracted load or merged store dword), response clear
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            err_q   <= 1'b0;
            size_q  <= 2'd0;
            addr_q  <= '0;
            wdata_q <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && req_valid) begin
                we_q    <= req_we;
                uns_q   <= req_unsigned;
                err_q   <= err;
                size_q  <= req_size;
                addr_q  <= addr_al;
                wdata_q <= req_wdata;
                data_q  <= req_wdata;
            end else if (state_q == CAP) begin
                data_q  <= we_q ? merged : loaded;
            end else if (state_q == RESP) begin
                err_q   <= 1'b0;
                data_q  <= '0;
            end
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed checks of the LSU against a registered-read data memory model
module tb_load_store_unit;
    logic        clk = 1'b0, reset = 1'b1;
    logic        req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic [63:0] req_addr = '0, req_wdata = '0;
    logic        req_ready, resp_valid, resp_err, mem_rd, mem_wr;
    logic [63:0] resp_rdata, mem_addr, mem_wr_data, mem_rd_data;
    logic [63:0] mem [0:31];
    int          errors = 0, checks = 0;
    int          lat, rd_cyc, wr_cyc;
    logic [63:0] rdata, wr_idx, wr_dat, after_d;
    logic        rerr, rd_seen, wr_seen, after_v, both_ever = 1'b0, bad_seen;

    load_store_unit dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
        .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_addr(mem_addr),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wr_data(mem_wr_data),
        .mem_rd_data(mem_rd_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) mem[i] <= '0;
            mem_rd_data <= '0;
        end else begin
            if (mem_wr) mem[mem_addr[4:0]] <= mem_wr_data;
            if (mem_rd) mem_rd_data <= mem[mem_addr[4:0]];
        end
        if (mem_rd && mem_wr) both_ever <= 1'b1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [63:0] a, input logic [63:0] d);
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns; req_addr = a; req_wdata = d;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0; rd_cyc = 0; wr_cyc = 0; rd_seen = 0; wr_seen = 0; wr_idx = '0; wr_dat = '0;
        rdata = 'x; rerr = 1'bx;
        for (int i = 1; i <= 8 && lat == 0; i++) begin
            if (i > 1) begin @(posedge clk); #1; end
            if (mem_rd) begin rd_seen = 1; rd_cyc = i; end
            if (mem_wr) begin wr_seen = 1; wr_cyc = i; wr_idx = mem_addr; wr_dat = mem_wr_data; end
            if (resp_valid) begin lat = i; rdata = resp_rdata; rerr = resp_err; end
        end
        @(posedge clk); #1;
        after_v = resp_valid;
        after_d = resp_rdata;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ready", 64'(req_ready), 64'd1);
        chk("reset_resp_valid", 64'(resp_valid), 64'd0);
        chk("reset_strobes", {62'd0, mem_rd, mem_wr}, 64'd0);
        chk("reset_addr", mem_addr, 64'd0);
        chk("reset_rdata", resp_rdata, 64'd0);
        @(negedge clk) reset = 1'b0;

        issue(1'b1, 2'd3, 1'b0, 64'h10, 64'h1122334455667788);
        chk("stD_lat", 64'(lat), 64'd2);
        chk("stD_wr_cyc", 64'(wr_cyc), 64'd1);
        chk("stD_wr_idx", wr_idx, 64'd2);
        chk("stD_wr_data", wr_dat, 64'h1122334455667788);
        chk("stD_no_rd", 64'(rd_seen), 64'd0);
        chk("stD_rdata", rdata, 64'd0);
        chk("stD_err", 64'(rerr), 64'd0);

        issue(1'b0, 2'd3, 1'b0, 64'h10, 64'h0);
        chk("ldD_lat", 64'(lat), 64'd3);
        chk("ldD_rdata", rdata, 64'h1122334455667788);
        chk("ldD_rd_cyc", 64'(rd_cyc), 64'd1);
        chk("ldD_no_wr", 64'(wr_seen), 64'd0);
        chk("ldD_pulse_one", 64'(after_v), 64'd0);
        chk("ldD_rdata_clear", after_d, 64'd0);

        issue(1'b1, 2'd0, 1'b0, 64'h13, 64'hFFFF_FFFF_FFFF_FFAB);
        chk("stB_lat", 64'(lat), 64'd4);
        chk("stB_rd_cyc", 64'(rd_cyc), 64'd1);
        chk("stB_wr_cyc", 64'(wr_cyc), 64'd3);
        chk("stB_wr_idx", wr_idx, 64'd2);
        chk("stB_wr_data", wr_dat, 64'h11223344AB667788);

        issue(1'b0, 2'd3, 1'b0, 64'h10, 64'h0);
        chk("ldD2_rdata", rdata, 64'h11223344AB667788);

        issue(1'b0, 2'd0, 1'b0, 64'h13, 64'h0);
        chk("ldB_signed", rdata, 64'hFFFF_FFFF_FFFF_FFAB);
        chk("ldB_signed_lat", 64'(lat), 64'd3);

        issue(1'b0, 2'd0, 1'b1, 64'h13, 64'h0);
        chk("ldB_unsigned", rdata, 64'h0000_0000_0000_00AB);

        issue(1'b0, 2'd2, 1'b0, 64'h100, 64'h0);
        chk("oor_err", 64'(rerr), 64'd1);
        chk("oor_lat", 64'(lat), 64'd1);
        chk("oor_rdata", rdata, 64'd0);
        chk("oor_no_strobe", {62'd0, rd_seen, wr_seen}, 64'd0);

        issue(1'b0, 2'd1, 1'b1, 64'h11, 64'h0);
`ifdef MISALIGN_TRAP_EN
        chk("ldH_mis_err", 64'(rerr), 64'd1);
        chk("ldH_mis_lat", 64'(lat), 64'd1);
        chk("ldH_mis_no_strobe", {62'd0, rd_seen, wr_seen}, 64'd0);
`else
        chk("ldH_mis_rdata", rdata, 64'h7788);
        chk("ldH_mis_lat", 64'(lat), 64'd3);
        chk("ldH_mis_err", 64'(rerr), 64'd0);
`endif

        issue(1'b1, 2'd2, 1'b0, 64'h1C, 64'h80000001);
        chk("stW_wr_data", wr_dat, 64'h80000001_00000000);
        chk("stW_wr_idx", wr_idx, 64'd3);
        issue(1'b0, 2'd2, 1'b0, 64'h1C, 64'h0);
        chk("ldW_signed", rdata, 64'hFFFF_FFFF_8000_0001);
        issue(1'b0, 2'd1, 1'b1, 64'h1E, 64'h0);
        chk("ldH_unsigned", rdata, 64'h8000);
        issue(1'b0, 2'd1, 1'b0, 64'h1E, 64'h0);
        chk("ldH_signed", rdata, 64'hFFFF_FFFF_FFFF_8000);

        issue(1'b1, 2'd3, 1'b0, 64'hF8, 64'hDEADBEEFCAFEF00D);
        chk("last_wr_idx", wr_idx, 64'd31);
        chk("last_err", 64'(rerr), 64'd0);
        issue(1'b0, 2'd3, 1'b0, 64'hF8, 64'h0);
        chk("last_rdata", rdata, 64'hDEADBEEFCAFEF00D);

        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_addr = 64'h10; req_wdata = 64'h5A;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("rst_mid_rd", 64'(mem_rd), 64'd1);
        @(posedge clk); #1;
        reset = 1'b1;
        bad_seen = mem_wr | resp_valid;
        @(posedge clk); #1;
        chk("rst_mid_ready", 64'(req_ready), 64'd1);
        @(negedge clk) reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            bad_seen = bad_seen | mem_wr | resp_valid;
        end
        chk("rst_mid_no_wr_resp", 64'(bad_seen), 64'd0);
        chk("rst_mid_idle", 64'(req_ready), 64'd1);
        chk("never_rd_and_wr", 64'(both_ever), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
